// File: rtl/mips_pipe_pkg.sv
// Shared field positions and hazard-controller state for the MIPS pipeline.
// The check_lw_ex and register-bundle slices used by the ID-stage hazard logic live here.
package mips_pipe_pkg;

  localparam int LW_VALID_BIT = 5;
  localparam int LW_DEST_MSB  = 4;
  localparam int LW_DEST_LSB  = 0;

  localparam int RS_MSB = 14;
  localparam int RS_LSB = 10;
  localparam int RT_MSB = 9;
  localparam int RT_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard controller: holds PC/IF-ID and bubbles ID/EX for LOAD_STALL_CYCLES per hazard.
// Stall/flush outputs are combinational (0 cycles); state and stall_count update at the next edge.
module load_use_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [14:0]            id_regs,
  input  logic                   id_uses_rt,
  input  logic [5:0]             check_lw_ex,
  input  logic                   flush_ex,
  output logic                   pc_write_en,
  output logic                   ifid_write_en,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   stall_active,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_t  state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic       hz;
  logic       stall_raw;
  logic       flush_raw;

  // $0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign hz = id_valid & check_lw_ex[LW_VALID_BIT]
            & (check_lw_ex[LW_DEST_MSB:LW_DEST_LSB] != 5'd0)
            & ((check_lw_ex[LW_DEST_MSB:LW_DEST_LSB] == id_regs[RS_MSB:RS_LSB])
               | (id_uses_rt & (check_lw_ex[LW_DEST_MSB:LW_DEST_LSB] == id_regs[RT_MSB:RT_LSB])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    stall_raw = 1'b0;
    flush_raw = 1'b0;
    case (state)
      RUN: begin
        if (flush_ex) begin
          flush_raw = 1'b1;
        end else if (hz) begin
          stall_raw = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nxt = STALL;
            rem_nxt   = REM_INIT;
          end
        end
      end
      STALL: begin
        if (flush_ex) begin
          flush_raw = 1'b1;
          state_nxt = RUN;
          rem_nxt   = 3'd0;
        end else begin
          // ID is frozen here, so hz is ignored until RUN resumes.
          stall_raw = 1'b1;
          if (rem <= 3'd1) begin
            state_nxt = RUN;
            rem_nxt   = 3'd0;
          end else begin
            rem_nxt = rem - 3'd1;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        rem_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs fall back to normal-cycle values for as long as reset is held.
  assign stall_active  = rst_n & stall_raw;
  assign ifid_flush    = rst_n & flush_raw;
  assign pc_write_en   = ~stall_active;
  assign ifid_write_en = ~stall_active;
  assign idex_bubble   = stall_active | ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_active && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Scoreboard bench: two controller instances (1 bubble / 16-bit count, 2 bubbles / 4-bit count)
// share the same stimulus; expectations come from a cycle-level model of the hazard rules.
module tb_load_use_hazard_ctrl;

  localparam int N_A = 1;
  localparam int W_A = 16;
  localparam int N_B = 2;
  localparam int W_B = 4;

  // {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active}
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11110;

  typedef struct {
    logic [4:0] oa;
    int         ca;
    logic [4:0] ob;
    int         cb;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [14:0] id_regs = '0;
  logic        id_uses_rt = 1'b0;
  logic [5:0]  check_lw_ex = '0;
  logic        flush_ex = 1'b0;

  logic           pc_a, ifw_a, ifl_a, bub_a, st_a;
  logic [W_A-1:0] cnt_a;
  logic           pc_b, ifw_b, ifl_b, bub_b, st_b;
  logic [W_B-1:0] cnt_b;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   left_a = 0, cnt_ma = 0;
  int   left_b = 0, cnt_mb = 0;

  always #5 clk = ~clk;

  load_use_hazard_ctrl #(.LOAD_STALL_CYCLES(N_A), .STALL_CNT_W(W_A)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_regs(id_regs),
    .id_uses_rt(id_uses_rt), .check_lw_ex(check_lw_ex), .flush_ex(flush_ex),
    .pc_write_en(pc_a), .ifid_write_en(ifw_a), .ifid_flush(ifl_a),
    .idex_bubble(bub_a), .stall_active(st_a), .stall_count(cnt_a)
  );

  load_use_hazard_ctrl #(.LOAD_STALL_CYCLES(N_B), .STALL_CNT_W(W_B)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_regs(id_regs),
    .id_uses_rt(id_uses_rt), .check_lw_ex(check_lw_ex), .flush_ex(flush_ex),
    .pc_write_en(pc_b), .ifid_write_en(ifw_b), .ifid_flush(ifl_b),
    .idex_bubble(bub_b), .stall_active(st_b), .stall_count(cnt_b)
  );

  // One cycle of the hazard rules: flush wins, then any owed bubbles, then a fresh hazard.
  task automatic model_step(input int n, input int maxc, input bit rst, input bit hz, input bit fl,
                            inout int left, inout int cnt, output logic [4:0] o, output int cnt_now);
    if (rst) begin
      left = 0;
      cnt = 0;
      o = O_NORM;
      cnt_now = 0;
    end else begin
      cnt_now = cnt;
      if (fl) begin
        o = O_FLUSH;
        left = 0;
      end else if (left > 0) begin
        o = O_STALL;
        left = left - 1;
      end else if (hz) begin
        o = O_STALL;
        left = n - 1;
      end else begin
        o = O_NORM;
      end
      if (o == O_STALL && cnt < maxc) cnt = cnt + 1;
    end
  endtask

  task automatic cyc(input string tag, input bit rn, input bit v, input logic [4:0] rs,
                     input logic [4:0] rt, input bit urt, input logic [5:0] lw, input bit fl);
    exp_t e;
    bit hz;
    @(posedge clk);
    #1;
    rst_n = rn; id_valid = v; id_regs = {rs, rt, 5'd3}; id_uses_rt = urt;
    check_lw_ex = lw; flush_ex = fl;
    hz = v && lw[5] && (lw[4:0] != 0) && (lw[4:0] == rs || (urt && lw[4:0] == rt));
    model_step(N_A, (1 << W_A) - 1, !rn, hz, fl, left_a, cnt_ma, e.oa, e.ca);
    model_step(N_B, (1 << W_B) - 1, !rn, hz, fl, left_b, cnt_mb, e.ob, e.cb);
    e.tag = tag;
    q.push_back(e);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // Monitor: at each falling edge compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    logic [4:0] oa, ob;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        oa = {pc_a, ifw_a, ifl_a, bub_a, st_a};
        ob = {pc_b, ifw_b, ifl_b, bub_b, st_b};
        checks += 4;
        if (oa !== e.oa) begin
          errors++;
          $display("FAIL %s outputs_n1: got %b expected %b", e.tag, oa, e.oa);
        end
        if (int'(cnt_a) != e.ca) begin
          errors++;
          $display("FAIL %s count_n1: got %0d expected %0d", e.tag, cnt_a, e.ca);
        end
        if (ob !== e.ob) begin
          errors++;
          $display("FAIL %s outputs_n2: got %b expected %b", e.tag, ob, e.ob);
        end
        if (int'(cnt_b) != e.cb) begin
          errors++;
          $display("FAIL %s count_n2: got %0d expected %0d", e.tag, cnt_b, e.cb);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc("reset0", 0, 1, 5'd8, 5'd0, 0, 6'b101000, 0);
    cyc("reset1", 0, 0, 5'd0, 5'd0, 0, 6'b000000, 0);
    cyc("idle",   1, 0, 5'd0, 5'd0, 0, 6'b000000, 0);
    // lw $8 followed by add using $8 as rs
    cyc("lw8_hz", 1, 1, 5'd8, 5'd1, 0, 6'b101000, 0);
    repeat (3) cyc("lw8_after", 1, 1, 5'd8, 5'd1, 0, 6'b000000, 0);
    cyc("dest0",  1, 1, 5'd0, 5'd0, 1, 6'b100000, 0);
    cyc("sw_rt",  1, 1, 5'd1, 5'd9, 1, 6'b101001, 0);
    repeat (2) cyc("sw_after", 1, 1, 5'd1, 5'd9, 1, 6'b000000, 0);
    cyc("no_rt",  1, 1, 5'd1, 5'd9, 0, 6'b101001, 0);
    cyc("invalid", 1, 0, 5'd9, 5'd9, 1, 6'b101001, 0);
    cyc("hz_flush", 1, 1, 5'd8, 5'd1, 0, 6'b101000, 1);
    cyc("idle2",  1, 1, 5'd2, 5'd1, 0, 6'b000000, 0);
    cyc("hz2",    1, 1, 5'd8, 5'd1, 0, 6'b101000, 0);
    cyc("flush_in_stall", 1, 1, 5'd8, 5'd1, 0, 6'b000000, 1);
    cyc("after_flush", 1, 1, 5'd2, 5'd1, 0, 6'b000000, 0);
    // reset pulse asserted in the middle of a stall
    cyc("hz3",    1, 1, 5'd8, 5'd1, 0, 6'b101000, 0);
    cyc("rst_mid", 0, 1, 5'd8, 5'd1, 0, 6'b101000, 0);
    cyc("rst_rel", 1, 1, 5'd2, 5'd1, 0, 6'b000000, 0);
    cyc("post_rst", 1, 1, 5'd2, 5'd1, 0, 6'b000000, 0);
    // sustained hazards to drive the 4-bit counter into saturation
    repeat (40) cyc("saturate", 1, 1, 5'd8, 5'd1, 0, 6'b101000, 0);
    cyc("sat_hold", 1, 1, 5'd2, 5'd1, 0, 6'b000000, 0);
    for (int i = 0; i < 600; i++) begin
      cyc("random", ($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
          pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
          {1'($urandom_range(0, 1)), pick_reg()}, ($urandom_range(0, 7) == 0));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
